// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle sequencer and the RV32I datapath.
// The controller takes the master view; the datapath takes the slave view.
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       instr_done;
    logic       error;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
               instr_done, error, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
               instr_done, error, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core: fetch/decode/execute/writeback
// over one shared memory port, with a memory-wait timeout and a sticky error trap.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input logic                      clk,
    input logic                      rst_n,
    multicycle_controller_if.master  bus
);
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ERROR    = 4'd11
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;
    logic             timeout;

    // States that hold the memory port and may stall on mem_ready.
    assign waiting = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign timeout = waiting && !bus.mem_ready && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (waiting && !bus.mem_ready) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.PCWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ResultSrc  = 2'b00;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ALUOp      = 2'b00;
        bus.ImmSrc     = 2'b00;
        bus.instr_done = 1'b0;
        bus.error      = 1'b0;
        bus.state      = 4'(state_q);

        case (bus.opcode)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BEQ:  bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase

        case (state_q)
            S_FETCH: begin
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = bus.mem_ready;
                bus.PCWrite   = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
                else if (timeout)  state_d = S_ERROR;
            end
            S_DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_ITYPE:     state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                if (bus.opcode == OP_LW)      state_d = S_MEMREAD;
                else if (bus.opcode == OP_SW) state_d = S_MEMWRITE;
                else                          state_d = S_ERROR;
            end
            S_MEMREAD: begin
                bus.AdrSrc = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
                else if (timeout)  state_d = S_ERROR;
            end
            S_MEMWB: begin
                bus.ResultSrc  = 2'b01;
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.AdrSrc     = 1'b1;
                bus.MemWrite   = 1'b1;
                bus.instr_done = bus.mem_ready;
                if (bus.mem_ready) state_d = S_FETCH;
                else if (timeout)  state_d = S_ERROR;
            end
            S_EXECR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUOp   = 2'b10;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = 2'b10;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_BEQ: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUOp      = 2'b01;
                bus.PCWrite    = bus.zero;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_JAL: begin
                // PC takes the jump target from ALUOut while the ALU forms OldPC+4 for rd.
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.PCWrite = 1'b1;
                state_d     = S_ALUWB;
            end
            S_ERROR: begin
                bus.error = 1'b1;
            end
            default: state_d = S_ERROR;
        endcase

        // Held reset forces every output low regardless of the stored state.
        if (!rst_n) begin
            bus.PCWrite    = 1'b0;
            bus.AdrSrc     = 1'b0;
            bus.MemWrite   = 1'b0;
            bus.IRWrite    = 1'b0;
            bus.RegWrite   = 1'b0;
            bus.ResultSrc  = 2'b00;
            bus.ALUSrcA    = 2'b00;
            bus.ALUSrcB    = 2'b00;
            bus.ALUOp      = 2'b00;
            bus.ImmSrc     = 2'b00;
            bus.instr_done = 1'b0;
            bus.error      = 1'b0;
            bus.state      = 4'd0;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table, hand-written
// multi-cycle sequences, and random instruction streams against a phase-list model.
module tb_multicycle_controller;
    localparam int unsigned MEM_TIMEOUT = 15;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b0000000;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] imm_src;
        logic       instr_done;
        logic       error;
        logic [3:0] state;
    } ctl_t;

    typedef struct {
        logic       rst_n;
        logic [6:0] opcode;
        logic       zero;
        logic       mem_ready;
        ctl_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    ctl_t base [12];
    vec_t dir  [13];
    vec_t q    [$];

    always #5 clk = ~clk;

    multicycle_controller_if bus_if ();

    multicycle_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    function automatic ctl_t mk(logic pc, logic adr, logic mw, logic ir, logic rw,
                                logic [1:0] res, logic [1:0] a, logic [1:0] b,
                                logic [1:0] op, logic [1:0] imm, logic done, logic err,
                                logic [3:0] st);
        ctl_t c;
        c.pc_write = pc;   c.adr_src = adr;   c.mem_write = mw; c.ir_write = ir;
        c.reg_write = rw;  c.result_src = res; c.alu_src_a = a; c.alu_src_b = b;
        c.alu_op = op;     c.imm_src = imm;   c.instr_done = done; c.error = err;
        c.state = st;
        return c;
    endfunction

    function automatic vec_t mkv(logic r, logic [6:0] op, logic z, logic mr, ctl_t e);
        vec_t v;
        v.rst_n = r; v.opcode = op; v.zero = z; v.mem_ready = mr; v.exp = e;
        return v;
    endfunction

    function automatic ctl_t observed();
        ctl_t c;
        c = {bus_if.PCWrite, bus_if.AdrSrc, bus_if.MemWrite, bus_if.IRWrite, bus_if.RegWrite,
             bus_if.ResultSrc, bus_if.ALUSrcA, bus_if.ALUSrcB, bus_if.ALUOp, bus_if.ImmSrc,
             bus_if.instr_done, bus_if.error, bus_if.state};
        return c;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [1:0] imm_of(logic [6:0] op);
        if (op == OP_SW)  return 2'b01;
        if (op == OP_BEQ) return 2'b10;
        if (op == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag, input int idx);
        ctl_t got;
        @(negedge clk);
        rst_n            = v.rst_n;
        bus_if.opcode    = v.opcode;
        bus_if.zero      = v.zero;
        bus_if.mem_ready = v.mem_ready;
        #1;
        got = observed();
        checks++;
        if (got !== v.exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h (op %b zero %b ready %b)",
                     tag, idx, got, v.exp, v.opcode, v.zero, v.mem_ready);
        end
    endtask

    task automatic step(input logic r, input logic mr, input logic z);
        @(negedge clk);
        rst_n            = r;
        bus_if.mem_ready = mr;
        bus_if.zero      = z;
        #1;
    endtask

    // Reference model: an instruction expands into its list of phases; each phase's
    // outputs come from the per-phase table plus the few input-dependent strobes.
    task automatic push_cyc(input int ph, input logic [6:0] op, input logic z, input logic mr);
        ctl_t c;
        c         = base[ph];
        c.state   = 4'(ph);
        c.imm_src = imm_of(op);
        if (ph == 0) begin
            c.ir_write = mr;
            c.pc_write = mr;
        end
        if (ph == 5) c.instr_done = mr;
        if (ph == 9) c.pc_write = z;
        q.push_back(mkv(1'b1, op, z, mr, c));
    endtask

    task automatic push_reset(input logic [6:0] op);
        q.push_back(mkv(1'b0, op, rbit(), rbit(), '0));
    endtask

    task automatic push_error_tail(input logic [6:0] op);
        repeat (3) push_cyc(11, op, rbit(), rbit());
        push_reset(op);
    endtask

    task automatic push_wait(input int ph, input logic [6:0] op, input int waits,
                             output bit timed_out);
        int n;
        n = (waits < int'(MEM_TIMEOUT)) ? waits : int'(MEM_TIMEOUT);
        for (int i = 0; i < n; i++) push_cyc(ph, op, rbit(), 1'b0);
        timed_out = (waits >= int'(MEM_TIMEOUT));
        if (!timed_out) push_cyc(ph, op, rbit(), 1'b1);
    endtask

    task automatic push_instr(input logic [6:0] op, input logic z, input int fw, input int mw);
        bit to;
        push_wait(0, op, fw, to);
        if (to) begin
            push_error_tail(op);
            return;
        end
        push_cyc(1, op, rbit(), rbit());
        case (op)
            OP_LW: begin
                push_cyc(2, op, rbit(), rbit());
                push_wait(3, op, mw, to);
                if (to) push_error_tail(op);
                else    push_cyc(4, op, rbit(), rbit());
            end
            OP_SW: begin
                push_cyc(2, op, rbit(), rbit());
                push_wait(5, op, mw, to);
                if (to) push_error_tail(op);
            end
            OP_R: begin
                push_cyc(6, op, rbit(), rbit());
                push_cyc(8, op, rbit(), rbit());
            end
            OP_I: begin
                push_cyc(7, op, rbit(), rbit());
                push_cyc(8, op, rbit(), rbit());
            end
            OP_BEQ: push_cyc(9, op, z, rbit());
            OP_JAL: begin
                push_cyc(10, op, rbit(), rbit());
                push_cyc(8, op, rbit(), rbit());
            end
            default: push_error_tail(op);
        endcase
    endtask

    task automatic run_queue(input string tag);
        int idx;
        idx = 0;
        while (q.size() > 0) begin
            apply(q.pop_front(), tag, idx);
            idx++;
        end
    endtask

    function automatic int rwait();
        int r;
        r = int'($urandom_range(0, 31));
        if (r < 18) return 0;
        if (r < 30) return int'($urandom_range(1, 14));
        return int'(MEM_TIMEOUT);
    endfunction

    initial begin
        int   cyc;
        int   cnt;
        logic flag;
        logic [6:0] op;

        rst_n            = 1'b0;
        bus_if.opcode    = OP_R;
        bus_if.zero      = 1'b0;
        bus_if.mem_ready = 1'b1;

        //               pc adr mw ir rw res    A      B      op     imm  done err st
        base[0]  = mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0, 4'd0);
        base[1]  = mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 4'd1);
        base[2]  = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 4'd2);
        base[3]  = mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 4'd3);
        base[4]  = mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 4'd4);
        base[5]  = mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 4'd5);
        base[6]  = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 4'd6);
        base[7]  = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 4'd7);
        base[8]  = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 4'd8);
        base[9]  = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 1, 0, 4'd9);
        base[10] = mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 4'd10);
        base[11] = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 4'd11);

        // Directed table: reset, R-type, jal, illegal opcode, reset out of ERROR.
        dir[0]  = mkv(0, OP_R,   0, 1, '0);
        dir[1]  = mkv(1, OP_R,   0, 1, mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0, 4'd0));
        dir[2]  = mkv(1, OP_R,   0, 1, mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 4'd1));
        dir[3]  = mkv(1, OP_R,   1, 1, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 4'd6));
        dir[4]  = mkv(1, OP_R,   0, 0, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 4'd8));
        dir[5]  = mkv(1, OP_JAL, 0, 1, mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11, 0, 0, 4'd0));
        dir[6]  = mkv(1, OP_JAL, 0, 1, mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11, 0, 0, 4'd1));
        dir[7]  = mkv(1, OP_JAL, 0, 0, mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 0, 0, 4'd10));
        dir[8]  = mkv(1, OP_JAL, 1, 1, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1, 0, 4'd8));
        dir[9]  = mkv(1, OP_BAD, 0, 1, mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0, 4'd0));
        dir[10] = mkv(1, OP_BAD, 0, 1, mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 4'd1));
        dir[11] = mkv(1, OP_BAD, 0, 1, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 4'd11));
        dir[12] = mkv(0, OP_BAD, 0, 1, '0);

        for (int i = 0; i < 13; i++) apply(dir[i], "dir", i);

        // lw with three wait cycles in MEMREAD: 8 cycles total, MEMREAD spans 4.
        bus_if.opcode = OP_LW;
        cyc = 0; cnt = 0; flag = 1'b0;
        while (!flag && cyc < 20) begin
            cyc++;
            step(1'b1, (cyc >= 4 && cyc <= 6) ? 1'b0 : 1'b1, 1'b0);
            if (bus_if.state == 4'd3) cnt++;
            if (bus_if.instr_done) begin
                flag = 1'b1;
                check_int("lw_writeback", int'(bus_if.RegWrite && bus_if.ResultSrc == 2'b01), 1);
            end
        end
        check_int("lw_cycles", cyc, 8);
        check_int("lw_memread_len", cnt, 4);

        // beq taken then not taken: 3 cycles each, PCWrite follows zero in BEQ.
        bus_if.opcode = OP_BEQ;
        for (int k = 0; k < 2; k++) begin
            cyc = 0; flag = 1'b0; cnt = -1;
            while (!flag && cyc < 10) begin
                cyc++;
                step(1'b1, 1'b1, (k == 0) ? 1'b1 : 1'b0);
                if (bus_if.state == 4'd9) cnt = int'(bus_if.PCWrite);
                flag = bus_if.instr_done;
            end
            check_int("beq_cycles", cyc, 3);
            check_int("beq_pcwrite", cnt, (k == 0) ? 1 : 0);
        end

        // sw starved for MEM_TIMEOUT cycles traps; ERROR is sticky until reset.
        bus_if.opcode = OP_SW;
        cyc = 0;
        while (!bus_if.error && cyc < 40) begin
            cyc++;
            step(1'b1, (cyc == 1) ? 1'b1 : 1'b0, 1'b0);
        end
        check_int("sw_timeout_cycle", cyc, 19);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b1);
            check_int("error_sticky", int'(bus_if.error && !bus_if.MemWrite && !bus_if.PCWrite
                                           && !bus_if.RegWrite && bus_if.state == 4'd11), 1);
        end
        step(1'b0, 1'b1, 1'b0);
        check_int("reset_outputs_zero", int'(observed() == '0), 1);
        step(1'b1, 1'b0, 1'b0);
        check_int("reset_recovers", int'(bus_if.state == 4'd0 && !bus_if.error), 1);

        // Model-driven corners: last permitted wait cycle, timeouts, mid-instruction reset.
        push_reset(OP_R);
        push_instr(OP_LW,  0, 0, 14);
        push_instr(OP_SW,  0, 14, 14);
        push_instr(OP_I,   0, 14, 0);
        push_instr(OP_SW,  0, 0, 15);
        push_instr(OP_LW,  0, 0, 15);
        push_instr(OP_R,   0, 15, 0);
        push_cyc(0, OP_LW, 0, 1);
        push_cyc(1, OP_LW, 0, 1);
        push_cyc(2, OP_LW, 0, 1);
        push_cyc(3, OP_LW, 0, 0);
        push_reset(OP_LW);
        push_instr(OP_JAL, 0, 2, 0);
        run_queue("corner");

        // Random instruction stream.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 7))
                0, 7:    op = OP_LW;
                1:       op = OP_SW;
                2:       op = OP_R;
                3:       op = OP_I;
                4:       op = OP_BEQ;
                5:       op = OP_JAL;
                default: op = 7'($urandom);
            endcase
            push_instr(op, rbit(), rwait(), rwait());
        end
        run_queue("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
